// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register result-latency countdowns beside the ID stage.
// The block flags RAW hazards (early or late operand use) and WAW hazards for
// the instruction in ID. It also keeps a saturating count of stall cycles.
module hazard_scoreboard #(
  parameter int REG_ADDR_W = 5,
  parameter int LAT_W      = 3,
  parameter int CNT_W      = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  id_valid,
  input  logic [REG_ADDR_W-1:0] id_rs1,
  input  logic                  id_rs1_used,
  input  logic [REG_ADDR_W-1:0] id_rs2,
  input  logic                  id_rs2_used,
  input  logic                  id_rs2_late,
  input  logic [REG_ADDR_W-1:0] id_rd,
  input  logic                  id_wen,
  input  logic [LAT_W-1:0]      id_lat,
  input  logic                  hold,
  input  logic                  flush,
  output logic                  stall,
  output logic [1:0]            stall_cause,
  output logic                  issue,
  output logic [CNT_W-1:0]      stall_count
);

  localparam int NREG = 1 << REG_ADDR_W;

  // x0 has no countdown entry; the read view below supplies a constant zero for it.
  logic [LAT_W-1:0] cnt_q  [1:NREG-1];
  logic [LAT_W-1:0] cnt_rd [NREG];

  logic [LAT_W-1:0] cnt_rs1;
  logic [LAT_W-1:0] cnt_rs2;
  logic [LAT_W-1:0] cnt_rd_dst;
  logic             raw1;
  logic             raw2e;
  logic             raw2l;
  logic             waw;
  logic             rd_write;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + CNT_W'(1);
  endfunction

  // Flat read view of the countdowns, with entry 0 hardwired to zero.
  always_comb begin
    cnt_rd[0] = '0;
    for (int r = 1; r < NREG; r++) begin
      cnt_rd[r] = cnt_q[r];
    end
  end

  assign cnt_rs1    = cnt_rd[id_rs1];
  assign cnt_rs2    = cnt_rd[id_rs2];
  assign cnt_rd_dst = cnt_rd[id_rd];

  // A late (store-data) consumer can use a result one cycle earlier, so it
  // only conflicts while more than one cycle remains.
  assign raw1  = id_rs1_used && (id_rs1 != '0) && (cnt_rs1 != '0);
  assign raw2e = id_rs2_used && !id_rs2_late && (id_rs2 != '0) && (cnt_rs2 != '0);
  assign raw2l = id_rs2_used && id_rs2_late && (id_rs2 != '0) && (cnt_rs2 > LAT_W'(1));
  // A younger write must not complete before an older write to the same rd.
  assign waw   = id_wen && (id_rd != '0) && (cnt_rd_dst > id_lat);

  assign stall    = id_valid && !flush && (raw1 || raw2e || raw2l || waw);
  assign issue    = id_valid && !stall && !hold && !flush;
  assign rd_write = issue && id_wen && (id_rd != '0);

  // Report the highest-priority hazard cause; zero whenever there is no stall.
  always_comb begin
    stall_cause = 2'd0;
    if (stall) begin
      if (raw1 || raw2e) begin
        stall_cause = 2'd1;
      end else if (raw2l) begin
        stall_cause = 2'd2;
      end else begin
        stall_cause = 2'd3;
      end
    end
  end

  // Countdowns decrement unless frozen; a new issue to rd overrides that entry's decrement.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int r = 1; r < NREG; r++) begin
        cnt_q[r] <= '0;
      end
    end else if (!hold) begin
      for (int r = 1; r < NREG; r++) begin
        if (rd_write && (id_rd == REG_ADDR_W'(r))) begin
          cnt_q[r] <= id_lat;
        end else if (cnt_q[r] != '0) begin
          cnt_q[r] <= cnt_q[r] - LAT_W'(1);
        end
      end
    end
  end

  // Stall cycles are counted only when the pipeline is not frozen.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_count <= '0;
    end else if (stall && !hold) begin
      stall_count <= sat_inc(stall_count);
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Testbench for hazard_scoreboard. The model tracks, per register, the
// non-frozen cycle index at which its result becomes forwardable.
module tb_hazard_scoreboard;

  localparam int RW   = 5;
  localparam int LW   = 3;
  localparam int CW   = 4;
  localparam int NREG = 32;
  localparam int SMAX = 15;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          id_valid = 1'b0;
  logic [RW-1:0] id_rs1 = '0;
  logic          id_rs1_used = 1'b0;
  logic [RW-1:0] id_rs2 = '0;
  logic          id_rs2_used = 1'b0;
  logic          id_rs2_late = 1'b0;
  logic [RW-1:0] id_rd = '0;
  logic          id_wen = 1'b0;
  logic [LW-1:0] id_lat = '0;
  logic          hold = 1'b0;
  logic          flush = 1'b0;
  logic          stall;
  logic [1:0]    stall_cause;
  logic          issue;
  logic [CW-1:0] stall_count;

  hazard_scoreboard #(.REG_ADDR_W(RW), .LAT_W(LW), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid),
    .id_rs1(id_rs1), .id_rs1_used(id_rs1_used),
    .id_rs2(id_rs2), .id_rs2_used(id_rs2_used), .id_rs2_late(id_rs2_late),
    .id_rd(id_rd), .id_wen(id_wen), .id_lat(id_lat),
    .hold(hold), .flush(flush),
    .stall(stall), .stall_cause(stall_cause), .issue(issue),
    .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    int cyc;
    bit stall;
    int cause;
    bit issue;
    int sc;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   failures = 0;
  int   cycle = 0;

  // Reference model state.
  int   ready_at[NREG];
  int   teff;
  int   sc;
  bit   last_stall;

  function automatic void model_reset();
    for (int r = 0; r < NREG; r++) ready_at[r] = 0;
    teff = 0;
    sc   = 0;
  endfunction

  function automatic int remaining(int r);
    int d;
    if (r == 0) return 0;
    d = ready_at[r] - teff;
    return (d > 0) ? d : 0;
  endfunction

  task automatic step(input bit v, input int rs1, input bit u1, input int rs2,
                      input bit u2, input bit late, input int rd, input bit wen,
                      input int lat, input bit hld = 1'b0, input bit fl = 1'b0,
                      input bit rst = 1'b0);
    exp_t e;
    bit r1, r2e, r2l, ww, st, is;
    int cause;
    @(posedge clk);
    #1;
    cycle++;
    id_valid = v; id_rs1 = RW'(rs1); id_rs1_used = u1;
    id_rs2 = RW'(rs2); id_rs2_used = u2; id_rs2_late = late;
    id_rd = RW'(rd); id_wen = wen; id_lat = LW'(lat);
    hold = hld; flush = fl;
    rst_n = !rst;
    if (rst) model_reset();
    r1  = u1 && remaining(rs1) > 0;
    r2e = u2 && !late && remaining(rs2) > 0;
    r2l = u2 && late && remaining(rs2) > 1;
    ww  = wen && rd != 0 && remaining(rd) > lat;
    st  = v && !fl && (r1 || r2e || r2l || ww);
    is  = v && !st && !hld && !fl;
    cause = !st ? 0 : (r1 || r2e) ? 1 : r2l ? 2 : 3;
    e.cyc = cycle; e.stall = st; e.cause = cause; e.issue = is; e.sc = sc;
    exp_q.push_back(e);
    last_stall = st;
    // Effect of the coming rising edge.
    if (!rst && !hld) begin
      if (st && sc < SMAX) sc++;
      if (is && wen && rd != 0) ready_at[rd] = teff + 1 + lat;
      teff++;
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic chk(input string name, input int cyc, input int got, input int exp);
    checks++;
    if (got != exp) begin
      failures++;
      $display("FAIL %s cycle=%0d got=%0d expected=%0d", name, cyc, got, exp);
    end
  endtask

  // Monitor: the outputs are presented every cycle; compare them mid-cycle
  // against the oldest pending expectation.
  always @(negedge clk) begin
    if (exp_q.size() > 0) begin
      exp_t e;
      e = exp_q.pop_front();
      chk("stall", e.cyc, int'(stall), int'(e.stall));
      chk("stall_cause", e.cyc, int'(stall_cause), e.cause);
      chk("issue", e.cyc, int'(issue), int'(e.issue));
      chk("stall_count", e.cyc, int'(stall_count), e.sc);
    end
  end

  initial begin
    int rs1, rs2, rd, lat;
    bit u1, u2, late, wen, v;
    model_reset();
    last_stall = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state and a plain instruction issuing.
    idle(2);
    step(1, 1, 1, 2, 1, 0, 4, 1, 0);

    // Load-use: one early stall, then issue; a late store consumer never stalls.
    step(1, 0, 0, 0, 0, 0, 5, 1, 1);
    step(1, 5, 1, 0, 0, 0, 6, 1, 0);
    step(1, 5, 1, 0, 0, 0, 6, 1, 0);
    step(1, 0, 0, 0, 0, 0, 5, 1, 1);
    step(1, 1, 1, 5, 1, 1, 0, 0, 0);
    idle(2);

    // Long latency: early consumer stalls 3, late consumer stalls 2.
    step(1, 0, 0, 0, 0, 0, 7, 1, 3);
    repeat (4) step(1, 7, 1, 0, 0, 0, 8, 1, 0);
    idle(3);
    step(1, 0, 0, 0, 0, 0, 7, 1, 3);
    repeat (3) step(1, 1, 1, 7, 1, 1, 0, 0, 0);
    idle(3);

    // Hold freezes the countdown mid-way; stalls under hold are not counted.
    step(1, 0, 0, 0, 0, 0, 9, 1, 2);
    step(1, 9, 1, 0, 0, 0, 10, 1, 0);
    repeat (4) step(1, 9, 1, 0, 0, 0, 10, 1, 0, 1);
    repeat (2) step(1, 9, 1, 0, 0, 0, 10, 1, 0);
    idle(2);

    // WAW on x3, then x0 as destination and source.
    step(1, 0, 0, 0, 0, 0, 3, 1, 3);
    repeat (3) step(1, 0, 0, 0, 0, 0, 3, 1, 1);
    step(1, 0, 0, 0, 0, 0, 0, 1, 7);
    step(1, 0, 1, 0, 1, 0, 0, 1, 0);
    idle(3);

    // Flush kills a stalled instruction without touching the countdown.
    step(1, 0, 0, 0, 0, 0, 11, 1, 3);
    step(1, 11, 1, 0, 0, 0, 12, 1, 0, 0, 1);
    repeat (3) step(1, 11, 1, 0, 0, 0, 12, 1, 0);
    idle(2);

    // Reset in the middle of a countdown discards it.
    step(1, 0, 0, 0, 0, 0, 5, 1, 3);
    step(1, 5, 1, 0, 0, 0, 6, 1, 0);
    step(1, 5, 1, 0, 0, 0, 6, 1, 0, 0, 0, 1);
    step(1, 5, 1, 0, 0, 0, 6, 1, 0);

    // Saturation of the stall counter.
    for (int k = 0; k < 3; k++) begin
      step(1, 0, 0, 0, 0, 0, 13, 1, 7);
      repeat (8) step(1, 13, 1, 0, 0, 0, 14, 1, 0);
    end
    step(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1);

    // Randomized traffic on a small register window to provoke hazards.
    rs1 = 0; rs2 = 0; rd = 0; lat = 0; u1 = 0; u2 = 0; late = 0; wen = 0; v = 0;
    for (int i = 0; i < 2000; i++) begin
      bit hld, fl, rst;
      if (!(last_stall && ($urandom % 5 != 0))) begin
        v    = ($urandom % 10) != 0;
        rs1  = $urandom_range(0, 7);
        rs2  = $urandom_range(0, 7);
        rd   = $urandom_range(0, 7);
        u1   = $urandom % 4 != 0;
        u2   = $urandom % 2 != 0;
        late = $urandom % 3 == 0;
        wen  = $urandom % 4 != 0;
        lat  = ($urandom % 3 == 0) ? $urandom_range(0, 7) : $urandom_range(0, 2);
      end
      hld = ($urandom % 8) == 0;
      fl  = ($urandom % 12) == 0;
      rst = ($urandom % 400) == 0;
      step(v, rs1, u1, rs2, u2, late, rd, wen, lat, hld, fl, rst);
    end

    idle(1);
    repeat (3) @(negedge clk);
    chk("queue_drained", cycle, exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hazard_scoreboard.md
# hazard_scoreboard

Parametrised load/multi-cycle hazard detector for the in-order RV32 pipeline, sitting beside the ID stage. Each issuing instruction records in a per-register countdown how many cycles remain until its result can be forwarded. The instruction in ID is then stalled on RAW (early- or late-use operand) or WAW conflicts. This generalises the single-load-latency interlock to arbitrary result latencies, late-consumed store data, pipeline-wide freeze, flush, and a stall performance counter.

## Interface
Parameters:
- REG_ADDR_W, 5: register index width; 2^REG_ADDR_W architectural registers, index 0 hardwired zero.
- LAT_W, 3: width of latency field and per-register counters; max latency 2^LAT_W-1.
- CNT_W, 32: width of the stall performance counter.

Ports (one clock; reset is asynchronous and active-low):
- clk  in  1  pipeline clock, all state on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a valid instruction.
- id_rs1  in  REG_ADDR_W  source 1 index.
- id_rs1_used  in  1  instruction reads rs1 (needed at EX).
- id_rs2  in  REG_ADDR_W  source 2 index.
- id_rs2_used  in  1  instruction reads rs2.
- id_rs2_late  in  1  rs2 needed one stage later (store data, consumed in MEM).
- id_rd  in  REG_ADDR_W  destination index.
- id_wen  in  1  instruction writes rd.
- id_lat  in  LAT_W  cycles after issue until result is forwardable (0 = ALU with forwarding, 1 = load).
- hold  in  1  global pipeline freeze (e.g. memory wait).
- flush  in  1  ID instruction is being killed this cycle.
- stall  out  1  combinational; hold ID/IF, inject bubble.
- stall_cause  out  2  combinational; 0 none, 1 RAW early, 2 RAW late, 3 WAW.
- issue  out  1  combinational; ID instruction advances to EX this cycle.
- stall_count  out  CNT_W  registered saturating count of stall cycles.

## Operation
- State: cnt[r] of LAT_W bits for r = 1..2^REG_ADDR_W-1; cnt[0] does not exist and reads as 0.
- raw1 = id_rs1_used & id_rs1!=0 & cnt[id_rs1]!=0.
- raw2e = id_rs2_used & !id_rs2_late & id_rs2!=0 & cnt[id_rs2]!=0.
- raw2l = id_rs2_used & id_rs2_late & id_rs2!=0 & cnt[id_rs2]>1.
- waw = id_wen & id_rd!=0 & cnt[id_rd] > id_lat (a younger write must not complete before an older one).
- stall = id_valid & !flush & (raw1|raw2e|raw2l|waw).
- stall_cause priority: 1 if raw1|raw2e, else 2 if raw2l, else 3 if waw, else 0. It is 0 whenever stall=0.
- issue = id_valid & !stall & !hold & !flush.
- Counter update each rising edge when hold=0: every nonzero cnt decrements by 1. Then, if issue & id_wen & id_rd!=0, cnt[id_rd] <= id_lat; this write overrides the decrement of that entry.
- hold=1: all cnt frozen, no issue update. stall output still evaluated (reported but not counted).
- flush=1: stall=0, issue=0, no cnt write. In-flight older entries keep counting down.
- stall_count increments on each edge with stall=1 & hold=0 and saturates at all-ones.

## Timing
- Reset (rst_n low, asynchronous): all cnt=0, stall_count=0. Outputs then read stall=0, stall_cause=0, and issue=id_valid&!hold&!flush. Reset mid-countdown discards all pending entries immediately.
- stall, stall_cause and issue have zero-cycle latency from the inputs and current cnt. No combinational path exists from stall back to the inputs inside the block.
- Latency semantics: an issue at edge t with id_lat=L gives cnt=L after t. A dependent early consumer stalls for L cycles. A late consumer stalls for max(L-1,0) cycles. Hold cycles extend both 1:1.
- Simultaneous issue-write and decrement of the same register: the write wins.
- id_lat=0 issue leaves cnt[rd]=0 (no stall ever generated).

## Test plan
- Reset: assert rst_n=0 mid-countdown (cnt[5]=3), release -> cnt all 0, stall_count=0, a dependent on x5 issues immediately.
- Load-use: issue rd=x5 lat=1, next ID reads rs1=x5 -> stall=1, cause=1 for exactly 1 cycle, then issue=1. Same case with rs2=x5 late (store) -> no stall.
- Long latency: issue rd=x7 lat=3. Early consumer stalls 3 cycles. Late rs2 consumer stalls 2 cycles with cause=2. stall_count +3 / +2 respectively.
- Hold: issue lat=2 to x9, consumer in ID, hold=1 for 4 cycles mid-countdown -> cnt[x9] frozen, stall_count unchanged during hold, total stall = 2 non-hold cycles.
- WAW and x0: cnt[x3]=3, ID writes x3 lat=1 -> stall cause=3 until cnt[x3]<=1. Any instruction with rd/rs=x0 -> never stalls and no state written.
- Flush and saturation: stalled instruction with flush=1 -> stall=0, issue=0, cnt unaffected. With CNT_W=4, 20 stall cycles -> stall_count=15.
